fr: RTL and testbench

- Flags register for the CPU datapath: a small edge-triggered register holding the ALU status flags (default 2 bits).
- Loads from the flags input on the rising clock edge when its active-low load strobe is asserted. Holds its value otherwise.
- Output drives the microsequencer/conditional-jump logic continuously.

---
 rtl/fr.sv | 44 ++++
 tb/tb_fr.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fr.sv
// fr: ALU status flags register with asynchronous active-low reset.
// Optional FR_BUS_EN adds a tri-state readback of the flags onto the data bus.
module fr #(
  parameter int unsigned WIDTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] in,
  input  logic             load_bar,
  output logic [WIDTH-1:0] out,
  input  logic             reset_bar
`ifdef FR_BUS_EN
  ,
  input  logic             en_bar,
  output logic [WIDTH-1:0] bus
`endif
);

  logic [WIDTH-1:0] flags_q;
  logic [WIDTH-1:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    if (!load_bar) begin
      flags_d = in;
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      flags_q <= RESET_VAL;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign out = flags_q;

`ifdef FR_BUS_EN
  // Released to Z so other sources can share the data bus.
  assign bus = en_bar ? {WIDTH{1'bz}} : flags_q;
`endif

endmodule

// File: tb/tb_fr.sv
// tb_fr: directed self-checking bench for the flags register fr.
// Build with +define+FR_BUS_EN to also exercise the bus readback.
module tb_fr;

  logic       clk;
  logic [1:0] in;
  logic       load_bar;
  logic [1:0] out;
  logic       reset_bar;
`ifdef FR_BUS_EN
  logic       en_bar;
  logic [1:0] bus;
`endif

  int n_chk;
  int n_pass;

  fr #(.WIDTH(2)) dut (
    .clk      (clk),
    .in       (in),
    .load_bar (load_bar),
    .out      (out),
    .reset_bar(reset_bar)
`ifdef FR_BUS_EN
    ,
    .en_bar   (en_bar),
    .bus      (bus)
`endif
  );

  task automatic check(input string tag,
                       input logic [1:0] obs,
                       input logic [1:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic rise();
    #4 clk = 1'b1;
    #1;
  endtask

  task automatic fall();
    #4 clk = 1'b0;
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    clk = 1'b0;
    in = 2'b11;
    load_bar = 1'b1;
    reset_bar = 1'b1;
`ifdef FR_BUS_EN
    en_bar = 1'b1;
`endif

    #3 reset_bar = 1'b0;
    #1 check("reset_async", out, 2'b00);
    load_bar = 1'b0;
    rise();
    check("reset_hold_edge", out, 2'b00);
    fall();
    reset_bar = 1'b1;
    load_bar = 1'b1;
    in = 2'b01;
    #2 check("no_load_no_edge", out, 2'b00);
    load_bar = 1'b0;
    #2 check("strobe_no_edge", out, 2'b00);

    rise();
    check("load_01", out, 2'b01);
    in = 2'b00;
    load_bar = 1'b1;
    fall();
    check("fall_no_change", out, 2'b01);
    rise();
    check("hold_01", out, 2'b01);
    fall();
    check("hold_01_fall", out, 2'b01);

    load_bar = 1'b0;
    in = 2'b00;
    rise();
    check("load_00", out, 2'b00);
    fall();
    in = 2'b10;
    rise();
    check("load_10", out, 2'b10);
    in = 2'b01;
    #2 check("in_change_clk_hi", out, 2'b10);
    fall();
    check("in_change_fall", out, 2'b10);
    in = 2'b11;
    rise();
    check("load_11", out, 2'b11);

    #2 reset_bar = 1'b0;
    #1 check("reset_mid_cycle", out, 2'b00);
    fall();
    load_bar = 1'b0;
    in = 2'b11;
    rise();
    check("reset_beats_load", out, 2'b00);
    fall();
    reset_bar = 1'b1;
    #1 check("reset_release", out, 2'b00);
    rise();
    check("load_after_release", out, 2'b11);
    fall();

    in = 2'b10;
    rise();
    check("preload_10", out, 2'b10);
    fall();
    load_bar = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in = 2'(i);
      rise();
      check("churn_hold", out, 2'b10);
      in = 2'(i + 1);
      fall();
      check("churn_hold_fall", out, 2'b10);
    end

`ifdef FR_BUS_EN
    en_bar = 1'b1;
    #1 check("bus_released", bus, 2'bzz);
    check("out_en_hi", out, 2'b10);
    en_bar = 1'b0;
    #1 check("bus_drive", bus, 2'b10);
    check("out_en_lo", out, 2'b10);
    rise();
    check("bus_drive_edge", bus, 2'b10);
    fall();
    en_bar = 1'b1;
    #1 check("bus_release_again", bus, 2'bzz);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
